// File: rtl/ex_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Runs radix-2 shift-add multiply or restoring divide over XLEN cycles and stalls the pipeline until the result is ready.
module ex_mdu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [4:0]      result_rd_o,
  output logic [1:0]      dbg_state
);

  // Handshake: the instruction is accepted in the IDLE cycle where start_i=1 and flush_i=0.
  // result_valid_o pulses for exactly one cycle with result_o/result_rd_o valid, and there is no back-pressure on it.

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q;
  logic              spec_q;
  logic [XLEN-1:0]   spec_val_q;
  logic [XLEN-1:0]   result_hold_q;
  logic [4:0]        rd_hold_q;

  // Operand decode at accept
  logic            is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, res_neg;
  logic [XLEN-1:0] spec_val;
  logic            accept;

  always_comb begin
    is_div   = op_i[2];
    is_rem   = op_i[2] & op_i[1];
    a_sgn    = op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
    div_zero = is_div && (b_i == '0);
    div_ovf  = (op_i == OP_DIV || op_i == OP_REM) &&
               (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
    special  = div_zero | div_ovf;
    res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
    spec_val = '0;
    if (div_zero)
      spec_val = op_i[1] ? a_i : {XLEN{1'b1}};
    else if (div_ovf)
      spec_val = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept   = (state_q == IDLE) && start_i && !flush_i;
  end

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // The shifted partial remainder can be XLEN+1 bits wide, so compare on acc_q[2*XLEN-1:XLEN-1].
    div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
    div_sub  = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
    div_next = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                      : {acc_q[2*XLEN-2:0], 1'b0};
  end

  // Final sign correction and result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, done_result;

  always_comb begin
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    done_result = '0;
    if (spec_q) begin
      done_result = spec_val_q;
    end else begin
      unique case (op_q)
        OP_MUL:                       done_result = prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: done_result = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              done_result = quot;
        OP_REM, OP_REMU:              done_result = rem;
        default:                      done_result = '0;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == CW'(XLEN-1))
            state_d = DONE;
        end
      end
      DONE: begin
        // start_i still shows the completing instruction here, so it is not looked at.
        state_d        = IDLE;
        result_valid_o = !flush_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      acc_q         <= '0;
      opnd_q        <= '0;
      neg_q         <= 1'b0;
      spec_q        <= 1'b0;
      spec_val_q    <= '0;
      result_hold_q <= '0;
      rd_hold_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= op_i;
            rd_q       <= rd_i;
            neg_q      <= res_neg;
            spec_q     <= special;
            spec_val_q <= spec_val;
            cnt_q      <= '0;
            opnd_q     <= is_div ? b_mag : a_mag;
            acc_q      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          end
        end
        CALC: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          if (!flush_i) begin
            result_hold_q <= done_result;
            rd_hold_q     <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o    = result_valid_o ? done_result : result_hold_q;
  assign result_rd_o = result_valid_o ? rd_q : rd_hold_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Directed bench for ex_mdu_ctrl: hand-computed RV32M results, latency, stall, flush and reset behaviour.
module tb_ex_mdu_ctrl;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic [4:0]  result_rd_o;
  logic [1:0]  dbg_state;

  ex_mdu_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_rd_o    (result_rd_o),
    .dbg_state      (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    #1;
    check_eq({tag, "_idle_at_accept"}, 32'(dbg_state), 32'd0);
    check_eq({tag, "_stall_at_accept"}, 32'(stall_o), 32'd1);
  endtask

  task automatic wait_result(input string tag, input logic [4:0] rd, input int exp_lat);
    int          lat = 0;
    int          stall_cnt = 0;
    logic [31:0] got = '0;
    logic [4:0]  got_rd = '0;
    logic        stall_at_valid = 1'b0;
    logic [31:0] exp = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start_i = 1'b0; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678;
      end
      #1;
      if (result_valid_o) begin
        lat = i; got = result_o; got_rd = result_rd_o; stall_at_valid = stall_o;
        break;
      end
      if (stall_o) stall_cnt++;
    end
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_result"}, got, exp);
    check_eq({tag, "_rd"}, 32'(got_rd), 32'(rd));
    check_eq({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat - 1));
    check_eq({tag, "_stall_at_valid"}, 32'(stall_at_valid), 32'd0);
  endtask

  task automatic count_pulses(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (result_valid_o) pulses++;
    end
    check_eq({tag, "_no_pulse"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; rd_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    check_eq("reset_stall", 32'(stall_o), 32'd0);
    check_eq("reset_valid", 32'(result_valid_o), 32'd0);
    check_eq("reset_result", result_o, 32'd0);
    check_eq("reset_rd", 32'(result_rd_o), 32'd0);
    rst_n = 1'b1;

    // 7 * -3 = -21
    exp_q.push_back(32'hFFFF_FFEB);
    issue("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_result("mul", 5'd5, 33);
    @(negedge clk);
    #1;
    check_eq("hold_valid", 32'(result_valid_o), 32'd0);
    check_eq("hold_result", result_o, 32'hFFFF_FFEB);
    check_eq("hold_rd", 32'(result_rd_o), 32'd5);

    exp_q.push_back(32'hFFFF_FFFE);
    issue("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    wait_result("mulhu", 5'd6, 33);
    exp_q.push_back(32'h0000_0000);
    issue("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    wait_result("mulh", 5'd7, 33);
    exp_q.push_back(32'hFFFF_FFFF);
    issue("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8);
    wait_result("mulhsu", 5'd8, 33);

    // -7 / 2 = -3 rem -1, issued back-to-back
    exp_q.push_back(32'hFFFF_FFFD);
    issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    wait_result("div", 5'd9, 33);
    exp_q.push_back(32'hFFFF_FFFF);
    issue("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
    wait_result("rem", 5'd10, 33);

    // 100 / 7 = 14 rem 2
    exp_q.push_back(32'd14);
    issue("divu", OP_DIVU, 32'd100, 32'd7, 5'd11);
    wait_result("divu", 5'd11, 33);
    exp_q.push_back(32'd2);
    issue("remu", OP_REMU, 32'd100, 32'd7, 5'd12);
    wait_result("remu", 5'd12, 33);

    // divide by zero and signed overflow finish one cycle after accept
    exp_q.push_back(32'hFFFF_FFFF);
    issue("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd13);
    wait_result("divu_by0", 5'd13, 1);
    exp_q.push_back(32'd5);
    issue("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd14);
    wait_result("remu_by0", 5'd14, 1);
    exp_q.push_back(32'h8000_0000);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    wait_result("div_ovf", 5'd15, 1);
    exp_q.push_back(32'h0000_0000);
    issue("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    wait_result("rem_ovf", 5'd16, 1);

    // flush at N+10 of a DIV
    issue("flush", OP_DIV, 32'd100, 32'd7, 5'd17);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) start_i = 1'b0;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check_eq("flush_stall", 32'(stall_o), 32'd0);
    check_eq("flush_valid", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check_eq("flush_idle", 32'(dbg_state), 32'd0);
    check_eq("flush_stall_after", 32'(stall_o), 32'd0);
    count_pulses("flush", 40);

    // start and flush together in IDLE
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MUL; a_i = 32'd3; b_i = 32'd4; rd_i = 5'd18;
    #1;
    check_eq("startflush_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check_eq("startflush_idle", 32'(dbg_state), 32'd0);
    count_pulses("startflush", 40);

    // reset at N+20 of a MUL
    issue("rst_mid", OP_MUL, 32'd7, 32'd9, 5'd19);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i == 1) start_i = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_mid_state", 32'(dbg_state), 32'd0);
    check_eq("rst_mid_stall", 32'(stall_o), 32'd0);
    check_eq("rst_mid_valid", 32'(result_valid_o), 32'd0);
    check_eq("rst_mid_result", result_o, 32'd0);
    check_eq("rst_mid_rd", 32'(result_rd_o), 32'd0);
    count_pulses("rst_mid", 40);

    exp_q.push_back(32'd63);
    issue("post_rst", OP_MUL, 32'd7, 32'd9, 5'd3);
    wait_result("post_rst", 5'd3, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
